// File: rtl/apu_aout_pkg.sv
// Shared widths, constants and helpers for the audio output scheduler.
package apu_aout_pkg;

  localparam int W_SAMPLE_DEF = 16;
  localparam int W_PWM_DEF    = 4;

  // Silence level for the default sample width.
  localparam logic [W_SAMPLE_DEF-1:0] MIDSCALE = 16'h8000;

  // Occupancy counter width: must be able to represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/apu_sync_fifo.sv
// Small synchronous FIFO; head word is presented combinationally on rdata.
module apu_sync_fifo
  import apu_aout_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [W-1:0]                  wdata,
  output logic [W-1:0]                  rdata,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Qualify requests and compute pointer/occupancy next state.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; cleared on reset so the head never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/apu_aout_sched.sv
// Sample-rate scheduler: buffers PCM samples and updates the modulator
// input only on sample ticks aligned to PWM frame boundaries.
module apu_aout_sched
  import apu_aout_pkg::*;
#(
  parameter int W_SAMPLE   = W_SAMPLE_DEF,
  parameter int W_PWM      = W_PWM_DEF,
  parameter int W_DIV      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [W_DIV-1:0]                   div,
  input  logic [W_SAMPLE-1:0]                in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [W_SAMPLE-1:0]                sdm_d,
  output logic                               sample_strobe,
  output logic                               underflow,
  input  logic                               underflow_clr,
  output logic [level_width(FIFO_DEPTH)-1:0] level
);

  localparam logic [W_SAMPLE-1:0] MID = W_SAMPLE'(1) << (W_SAMPLE - 1);

  logic [W_PWM-1:0]    frm_q, frm_d;
  logic [W_DIV-1:0]    div_q, div_d;
  logic [W_SAMPLE-1:0] out_q, out_d;
  logic                strobe_q, strobe_d;
  logic                uf_q, uf_d;
  logic                frame_end, tick, pop, push;
  logic                fifo_full, fifo_empty;
  logic [W_SAMPLE-1:0] fifo_head;

  // Pushes are refused when full even if the same cycle pops: no pass-through.
  assign push          = in_valid && !fifo_full;
  assign in_ready      = !fifo_full;
  assign sdm_d         = out_q;
  assign sample_strobe = strobe_q;
  assign underflow     = uf_q;

  apu_sync_fifo #(
    .W     (W_SAMPLE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Frame timing, period divider, output selection and underflow next state.
  always_comb begin
    frame_end = en && (frm_q == '1);
    tick      = frame_end && (div_q == '0);
    pop       = tick && !fifo_empty;
    strobe_d  = pop;
    frm_d     = en ? frm_q + W_PWM'(1) : '0;
    if (!en) begin
      div_d = '0;
    end else if (frame_end) begin
      div_d = tick ? div : div_q - W_DIV'(1);
    end else begin
      div_d = div_q;
    end
    if (!en) begin
      out_d = MID;
    end else if (pop) begin
      out_d = fifo_head;
    end else begin
      out_d = out_q;
    end
    // A new underflow event outranks a simultaneous clear request.
    if (tick && fifo_empty) begin
      uf_d = 1'b1;
    end else if (underflow_clr) begin
      uf_d = 1'b0;
    end else begin
      uf_d = uf_q;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_q    <= '0;
      div_q    <= '0;
      out_q    <= MID;
      strobe_q <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      frm_q    <= frm_d;
      div_q    <= div_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
    end
  end

endmodule

// File: tb/tb_apu_aout_sched.sv
// Self-checking bench for apu_aout_sched (W_PWM=4, FIFO_DEPTH=4).
module tb_apu_aout_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] div;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sdm_d;
  logic        sample_strobe;
  logic        underflow;
  logic        underflow_clr;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb[$];
  logic [15:0] last_exp = 16'h8000;

  apu_aout_sched dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .div           (div),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sdm_d         (sdm_d),
    .sample_strobe (sample_strobe),
    .underflow     (underflow),
    .underflow_clr (underflow_clr),
    .level         (level)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe must present the oldest accepted sample.
  always @(negedge clk) begin
    if (sample_strobe === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected: sdm_d=%h, required no strobe (no sample pending)", sdm_d);
      end else begin
        last_exp = sb.pop_front();
        if (sdm_d !== last_exp) begin
          n_err++;
          $display("FAIL strobe_data: sdm_d=%h required %h", sdm_d, last_exp);
        end
      end
    end
  end

  // Offer one sample, holding valid until accepted or the budget runs out.
  task automatic push_sample(input logic [15:0] d, input int budget, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!ok && waited < budget) begin
      if (in_ready) begin
        ok = 1'b1;
        sb.push_back(d);
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    int strobes = 0;
    int sdm_bad = 0;
    rst = 1'b1; en = 1'b0; div = 12'd0; in_data = 16'h0000;
    in_valid = 1'b0; underflow_clr = 1'b0;
    #1;
    n_cmp++; if (sdm_d !== 16'h8000) begin n_err++; $display("FAIL rst_sdm: got %h required 8000", sdm_d); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b required 1", in_ready); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d required 0", level); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow: got %b required 0", underflow); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sample_strobe !== 1'b0) strobes++;
      if (sdm_d !== 16'h8000) sdm_bad++;
    end
    n_cmp++; if (strobes != 0) begin n_err++; $display("FAIL idle_strobes: got %0d required 0", strobes); end
    n_cmp++; if (sdm_bad != 0) begin n_err++; $display("FAIL idle_sdm: %0d cycles off midscale, required 0", sdm_bad); end
  endtask

  task automatic test_prefill();
    bit ok;
    int w;
    int first = -1;
    int second = -1;
    push_sample(16'h1000, 4, ok, w);
    push_sample(16'h2000, 4, ok, w);
    n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL prefill_level: got %0d required 2", level); end
    n_cmp++; if (sdm_d !== 16'h8000) begin n_err++; $display("FAIL prefill_sdm: got %h required 8000", sdm_d); end
    div = 12'd2;
    en = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (sample_strobe === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (i == 16) begin
        n_cmp++; if (sdm_d !== 16'h1000) begin n_err++; $display("FAIL first_sample: got %h required 1000", sdm_d); end
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL first_level: got %0d required 1", level); end
      end
    end
    n_cmp++; if (first != 16) begin n_err++; $display("FAIL first_tick_time: got %0d required 16", first); end
    n_cmp++; if (second != 64) begin n_err++; $display("FAIL second_tick_time: got %0d required 64", second); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int w;
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_sample(16'h3000 + 16'(i * 256), 2, ok, w);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b required 0", in_ready); end
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d required 4", level); end
    div = 12'd0;
    en = 1'b1;
    push_sample(16'h3400, 40, ok, w);
    n_cmp++; if (!ok || w != 16) begin n_err++; $display("FAIL fifth_accept: accepted=%b after %0d cycles, required 1 after 16", ok, w); end
    n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL refill_level: got %0d required 4", level); end
  endtask

  task automatic test_underflow();
    int rise = -1;
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL clr_initial: got %b required 0", underflow); end
    for (int i = 0; i < 120 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL drain_timeout: %0d samples pending, required 0", sb.size()); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (underflow === 1'b1) begin rise = i; break; end
    end
    n_cmp++; if (rise < 0) begin n_err++; $display("FAIL underflow_set: got %b required 1", underflow); end
    n_cmp++; if (sdm_d !== last_exp) begin n_err++; $display("FAIL underflow_hold: got %h required %h", sdm_d, last_exp); end
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL clr_midframe: got %b required 0", underflow); end
    repeat (14) @(negedge clk);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL set_wins: got %b required 1", underflow); end
  endtask

  task automatic test_div_change();
    bit ok;
    int w;
    int idx[$];
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_sample(16'h5000 + 16'(i * 256), 2, ok, w);
    div = 12'd5;
    en = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (i == 40) div = 12'd1;
      if (sample_strobe === 1'b1) idx.push_back(i);
    end
    n_cmp++;
    if (idx.size() != 3 || idx[0] != 16 || idx[1] != 112 || idx[2] != 144) begin
      n_err++;
      $display("FAIL div_change_times: got %0d strobes, at %p, required 16 112 144", idx.size(), idx);
    end
  endtask

  task automatic test_disable_and_reset();
    bit ok;
    int w;
    int strobes = 0;
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_sample(16'h6000 + 16'(i * 256), 2, ok, w);
    div = 12'd7;
    en = 1'b1;
    repeat (16) @(negedge clk);
    n_cmp++; if (sdm_d !== 16'h6000) begin n_err++; $display("FAIL en_first: got %h required 6000", sdm_d); end
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    n_cmp++; if (sdm_d !== 16'h8000) begin n_err++; $display("FAIL dis_sdm: got %h required 8000", sdm_d); end
    n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL dis_level: got %0d required 2", level); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sample_strobe !== 1'b0) strobes++;
    end
    n_cmp++; if (strobes != 0 || level !== 3'd2) begin n_err++; $display("FAIL dis_hold: strobes=%0d level=%0d required 0 and 2", strobes, level); end
    en = 1'b1;
    repeat (16) @(negedge clk);
    n_cmp++; if (sdm_d !== 16'h6100 || level !== 3'd1) begin n_err++; $display("FAIL reen: sdm=%h level=%0d required 6100 and 1", sdm_d, level); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (sdm_d !== 16'h8000) begin n_err++; $display("FAIL async_sdm: got %h required 8000", sdm_d); end
    n_cmp++; if (level !== 3'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL async_fifo: level=%0d ready=%b required 0 and 1", level, in_ready); end
    n_cmp++; if (underflow !== 1'b0 || sample_strobe !== 1'b0) begin n_err++; $display("FAIL async_flags: uf=%b strobe=%b required 0 and 0", underflow, sample_strobe); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_strobe !== 1'b0) strobes++;
    end
    n_cmp++; if (strobes != 0) begin n_err++; $display("FAIL post_reset_strobe: got %0d required 0", strobes); end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_prefill();
    test_back_to_back();
    test_underflow();
    test_div_change();
    test_disable_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
